// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU: FSM states, opcode map and
// flag bit positions within the {negative, overflow, carry, zero} vector.
package cpu_pkg;

    typedef enum logic [2:0] {
        F0   = 3'd0,
        F1   = 3'd1,
        F2   = 3'd2,
        F3   = 3'd3,
        EX   = 3'd4,
        HALT = 3'd5
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_SUB = 4'd1;
    localparam logic [3:0] ALU_AND = 4'd2;
    localparam logic [3:0] ALU_OR  = 4'd3;
    localparam logic [3:0] ALU_XOR = 4'd4;
    localparam logic [3:0] ALU_NOT = 4'd5;
    localparam logic [3:0] ALU_SHL = 4'd6;
    localparam logic [3:0] ALU_SHR = 4'd7;

    localparam logic [6:0] OP_LDI  = 7'h10;
    localparam logic [6:0] OP_JMP  = 7'h20;
    localparam logic [6:0] OP_JZ   = 7'h21;
    localparam logic [6:0] OP_HALT = 7'h7F;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_param.sv
// Combinational ALU: eight operations plus pass-b, producing the result and
// the {negative, overflow, carry, zero} flag vector.
module alu_param
    import cpu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] result,
    output logic [3:0]        flags
);

    localparam int MSB = DATA_W - 1;

    logic [DATA_W:0] sum;
    logic [DATA_W:0] diff;
    logic            carry;
    logic            ovf;

    assign sum  = {1'b0, a} + {1'b0, b};
    // The extra top bit of the difference is the borrow out of the subtraction.
    assign diff = {1'b0, a} - {1'b0, b};

    always_comb begin
        result = b;
        carry  = 1'b0;
        ovf    = 1'b0;
        case (op)
            ALU_ADD: begin
                result = sum[DATA_W-1:0];
                carry  = sum[DATA_W];
                ovf    = (a[MSB] == b[MSB]) && (sum[MSB] != a[MSB]);
            end
            ALU_SUB: begin
                result = diff[DATA_W-1:0];
                carry  = diff[DATA_W];
                ovf    = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]);
            end
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_NOT: result = ~a;
            ALU_SHL: begin
                result = {a[DATA_W-2:0], 1'b0};
                carry  = a[MSB];
            end
            ALU_SHR: begin
                result = {1'b0, a[DATA_W-1:1]};
                carry  = a[0];
            end
            default: result = b;
        endcase
    end

    always_comb begin
        flags         = 4'b0000;
        flags[FLAG_Z] = (result == '0);
        flags[FLAG_C] = carry;
        flags[FLAG_V] = ovf;
        flags[FLAG_N] = result[MSB];
    end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle CPU core: fetches 2- or 4-byte instructions one byte per
// handshake, then executes ALU, load-immediate, jump and halt in one EX cycle.
module cpu_multicycle
    import cpu_pkg::*;
#(
    parameter int                DATA_W    = 8,
    parameter int                ADDR_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_rvalid,
    output logic [ADDR_W-1:0] pc,
    output logic [3:0]        flags,
    output logic              halted,
    output logic              illegal,
    output logic [2:0]        dbg_state
);

    // Memory read handshake: a byte transfers on any cycle where mem_rd and
    // mem_rvalid are both high (rvalid may arrive in the same cycle as rd).
    // While mem_rd is high without rvalid, mem_addr holds steady; rvalid
    // outside a request is ignored.

    state_t            state;
    logic              fetch_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        b0, b1, b2, b3;
    logic [DATA_W-1:0] regs [8];

    logic              is_ext;
    logic [6:0]        op;
    logic [2:0]        rs1, rs2, rd;
    logic [DATA_W-1:0] imm;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc_len;
    logic [ADDR_W-1:0] next_pc;
    logic              do_alu, do_ldi, do_jmp, do_jz, do_halt, bad_op;
    logic [DATA_W-1:0] alu_b;
    logic [DATA_W-1:0] alu_result;
    logic [3:0]        alu_flags;

    // A pending request is dropped combinationally so mem_rd is low in the
    // very cycle reset is asserted.
    assign mem_rd    = fetch_q && !reset;
    assign mem_addr  = addr_q;
    assign dbg_state = state;

    assign is_ext = b0[7];
    assign op     = b0[6:0];
    assign rs1    = b1[7:5];
    assign rs2    = b1[4:2];
    assign rd     = is_ext ? b2[2:0] : {1'b0, b1[1:0]};
    assign imm    = DATA_W'(b3);
    assign target = ADDR_W'({b2, b3});
    assign pc_len = pc + (is_ext ? ADDR_W'(4) : ADDR_W'(2));

    assign do_alu  = (op[6:4] == 3'b000);
    assign do_ldi  = is_ext && (op == OP_LDI);
    assign do_jmp  = is_ext && (op == OP_JMP);
    assign do_jz   = is_ext && (op == OP_JZ);
    assign do_halt = (op == OP_HALT);
    assign bad_op  = !(do_alu || do_ldi || do_jmp || do_jz || do_halt);

    // A halted core keeps pc on the HALT instruction itself.
    assign next_pc = do_jmp                   ? target :
                     (do_jz && flags[FLAG_Z]) ? target :
                     do_halt                  ? pc     : pc_len;

    assign alu_b = is_ext ? imm : regs[rs2];

    alu_param #(.DATA_W(DATA_W)) u_alu (
        .a      (regs[rs1]),
        .b      (alu_b),
        .op     (op[3:0]),
        .result (alu_result),
        .flags  (alu_flags)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= F0;
            pc      <= RESET_VEC;
            flags   <= 4'b0000;
            halted  <= 1'b0;
            illegal <= 1'b0;
            fetch_q <= 1'b1;
            addr_q  <= RESET_VEC;
            for (int i = 0; i < 8; i++) begin
                regs[i] <= '0;
            end
        end else begin
            case (state)
                F0: if (mem_rvalid) begin
                    b0     <= mem_rdata;
                    addr_q <= pc + ADDR_W'(1);
                    state  <= F1;
                end
                F1: if (mem_rvalid) begin
                    b1 <= mem_rdata;
                    if (b0[7]) begin
                        addr_q <= pc + ADDR_W'(2);
                        state  <= F2;
                    end else begin
                        fetch_q <= 1'b0;
                        state   <= EX;
                    end
                end
                F2: if (mem_rvalid) begin
                    b2     <= mem_rdata;
                    addr_q <= pc + ADDR_W'(3);
                    state  <= F3;
                end
                F3: if (mem_rvalid) begin
                    b3      <= mem_rdata;
                    fetch_q <= 1'b0;
                    state   <= EX;
                end
                EX: begin
                    pc <= next_pc;
                    if (do_alu) begin
                        regs[rd] <= alu_result;
                        flags    <= alu_flags;
                    end else if (do_ldi) begin
                        regs[rd] <= imm;
                    end
                    if (bad_op) begin
                        illegal <= 1'b1;
                    end
                    if (do_halt) begin
                        halted <= 1'b1;
                        state  <= HALT;
                    end else begin
                        fetch_q <= 1'b1;
                        addr_q  <= next_pc;
                        state   <= F0;
                    end
                end
                HALT: state <= HALT;
                default: begin
                    fetch_q <= 1'b1;
                    addr_q  <= pc;
                    state   <= F0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cpu_multicycle.sv
// Directed bench for cpu_multicycle: small programs in a byte memory model,
// checked against hand-computed register, flag, pc and fetch-address values.
module tb_cpu_multicycle;
    import cpu_pkg::*;

    // clock / reset
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [7:0]  mem_rdata;
    logic        mem_rvalid;
    logic [15:0] pc;
    logic [3:0]  flags;
    logic        halted, illegal;
    logic [2:0]  dbg_state;

    logic        w_reset = 1'b1;
    logic [15:0] w_mem_addr;
    logic        w_mem_rd;
    logic [7:0]  w_mem_rdata;
    logic        w_mem_rvalid;
    logic [15:0] w_pc;
    logic [3:0]  w_flags;
    logic        w_halted, w_illegal;
    logic [2:0]  w_dbg_state;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] mem   [0:65535];
    logic [7:0] w_mem [0:65535];

    cpu_multicycle #(.DATA_W(8), .ADDR_W(16), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .reset(reset), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid), .pc(pc), .flags(flags),
        .halted(halted), .illegal(illegal), .dbg_state(dbg_state)
    );

    cpu_multicycle #(.DATA_W(8), .ADDR_W(16), .RESET_VEC(16'hFFFE)) dut_w (
        .clk(clk), .reset(w_reset), .mem_addr(w_mem_addr), .mem_rd(w_mem_rd),
        .mem_rdata(w_mem_rdata), .mem_rvalid(w_mem_rvalid), .pc(w_pc), .flags(w_flags),
        .halted(w_halted), .illegal(w_illegal), .dbg_state(w_dbg_state)
    );

    // memory models: main one with optional random wait states, wrap one zero-wait
    logic       rand_mode = 1'b0;
    logic [2:0] wait_cnt  = 3'd0;

    assign mem_rvalid   = mem_rd && (wait_cnt == 3'd0);
    assign mem_rdata    = mem[mem_addr];
    assign w_mem_rvalid = w_mem_rd;
    assign w_mem_rdata  = w_mem[w_mem_addr];

    always @(posedge clk) begin
        if (reset) begin
            wait_cnt <= 3'd0;
        end else if (mem_rd) begin
            if (wait_cnt == 3'd0) wait_cnt <= rand_mode ? 3'($urandom_range(0, 4)) : 3'd0;
            else                  wait_cnt <= wait_cnt - 3'd1;
        end
    end

    // address stability monitor and wrap-DUT fetch log
    logic        prev_stall = 1'b0;
    logic [15:0] prev_addr  = 16'h0;
    logic        stab_viol  = 1'b0;
    int          stall_cnt  = 0;
    logic [15:0] w_addrs[$];

    always @(negedge clk) begin
        if (!reset && prev_stall && mem_rd && (mem_addr !== prev_addr)) stab_viol <= 1'b1;
        if (!reset && mem_rd && !mem_rvalid) stall_cnt <= stall_cnt + 1;
        prev_stall <= !reset && mem_rd && !mem_rvalid;
        prev_addr  <= mem_addr;
    end

    always @(negedge clk) begin
        if (!w_reset && w_mem_rd && w_mem_rvalid) w_addrs.push_back(w_mem_addr);
    end

    // driver / check tasks
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put2(input logic [15:0] a, input logic [7:0] x0, input logic [7:0] x1);
        mem[a]         = x0;
        mem[a + 16'd1] = x1;
    endtask

    task automatic put4(input logic [15:0] a, input logic [7:0] x0, input logic [7:0] x1,
                        input logic [7:0] x2, input logic [7:0] x3);
        put2(a, x0, x1);
        put2(a + 16'd2, x2, x3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("rst_mem_rd_low", mem_rd, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
    endtask

    task automatic run_to_halt(input int budget, output int cycles);
        cycles = 0;
        while (!halted && cycles < budget) begin
            @(negedge clk);
            cycles++;
        end
        check("halt_reached", halted, 1'b1);
    endtask

    task automatic load_prog1();
        put4(16'h0000, 8'h90, 8'h00, 8'h01, 8'h05);  // LDI r1,0x05
        put4(16'h0004, 8'h90, 8'h00, 8'h02, 8'h03);  // LDI r2,0x03
        put2(16'h0008, 8'h00, 8'h2B);                // ADD r3 = r1 + r2
        put2(16'h000A, 8'h7F, 8'h00);                // HALT
    endtask

    int cyc;

    initial begin
        // test 1: reset state and basic program, zero-wait memory
        load_prog1();
        do_reset();
        check("rst_pc", pc, 16'h0000);
        check("rst_flags", flags, 4'b0000);
        check("rst_halted", halted, 1'b0);
        check("rst_illegal", illegal, 1'b0);
        check("rst_state", dbg_state, F0);
        check("rst_r1", dut.regs[1], 8'h00);
        check("f0_mem_rd", mem_rd, 1'b1);
        check("f0_mem_addr", mem_addr, 16'h0000);
        run_to_halt(100, cyc);
        check("t1_cycles", cyc, 16);
        check("t1_r1", dut.regs[1], 8'h05);
        check("t1_r2", dut.regs[2], 8'h03);
        check("t1_r3", dut.regs[3], 8'h08);
        check("t1_flags", flags, 4'b0000);
        check("t1_state", dbg_state, HALT);
        @(negedge clk);
        check("t1_halt_mem_rd", mem_rd, 1'b0);

        // test 2: 0xFF + #1 wraps to zero with carry, no overflow
        put4(16'h0000, 8'h90, 8'h00, 8'h01, 8'hFF);  // LDI r1,0xFF
        put4(16'h0004, 8'h80, 8'h20, 8'h04, 8'h01);  // ADD r4 = r1 + #1
        put2(16'h0008, 8'h7F, 8'h00);
        do_reset();
        run_to_halt(100, cyc);
        check("t2_r4", dut.regs[4], 8'h00);
        check("t2_flags", flags, 4'b0011);

        // test 3: program 1 with random 0-4 cycle wait states
        load_prog1();
        rand_mode = 1'b1;
        do_reset();
        run_to_halt(400, cyc);
        rand_mode = 1'b0;
        check("t3_r3", dut.regs[3], 8'h08);
        check("t3_flags", flags, 4'b0000);
        check("t3_addr_stable", stab_viol, 1'b0);
        check("t3_stalls_seen", (stall_cnt != 0), 1'b1);

        // test 4a: SUB sets zero, JZ taken to 0x0040
        put4(16'h0000, 8'h90, 8'h00, 8'h01, 8'h07);  // LDI r1,0x07
        put2(16'h0004, 8'h01, 8'h25);                // SUB r1 = r1 - r1
        put4(16'h0006, 8'hA1, 8'h00, 8'h00, 8'h40);  // JZ 0x0040
        put4(16'h000A, 8'h90, 8'h00, 8'h05, 8'hAA);  // LDI r5,0xAA
        put2(16'h000E, 8'h7F, 8'h00);
        put4(16'h0040, 8'h90, 8'h00, 8'h05, 8'h55);  // LDI r5,0x55
        put2(16'h0044, 8'h7F, 8'h00);
        do_reset();
        run_to_halt(100, cyc);
        check("t4a_r1", dut.regs[1], 8'h00);
        check("t4a_flags", flags, 4'b0001);
        check("t4a_r5", dut.regs[5], 8'h55);
        check("t4a_pc", pc, 16'h0044);

        // test 4b: SUB r1 - r2 = 7, JZ falls through to pc+4
        put2(16'h0004, 8'h01, 8'h29);
        do_reset();
        run_to_halt(100, cyc);
        check("t4b_r1", dut.regs[1], 8'h07);
        check("t4b_flags", flags, 4'b0000);
        check("t4b_r5", dut.regs[5], 8'hAA);
        check("t4b_pc", pc, 16'h000E);

        // test 5: fetch wraps from 0xFFFF to 0x0000
        w_mem[16'hFFFE] = 8'h00;  // ADD r0 = r0 + r0
        w_mem[16'hFFFF] = 8'h00;
        w_mem[16'h0000] = 8'h7F;  // HALT
        w_mem[16'h0001] = 8'h00;
        @(negedge clk);
        w_reset = 1'b0;
        for (int i = 0; i < 20 && !w_halted; i++) @(negedge clk);
        check("t5_halted", w_halted, 1'b1);
        check("t5_n_fetch", w_addrs.size(), 4);
        check("t5_fetch0", w_addrs[0], 16'hFFFE);
        check("t5_fetch1", w_addrs[1], 16'hFFFF);
        check("t5_fetch2", w_addrs[2], 16'h0000);
        check("t5_fetch3", w_addrs[3], 16'h0001);
        check("t5_pc", w_pc, 16'h0000);
        check("t5_flags", w_flags, 4'b0001);
        check("t5_illegal", w_illegal, 1'b0);
        check("t5_state", w_dbg_state, HALT);

        // test 6a: undefined opcode 0x33 is a NOP that sets illegal
        put4(16'h0000, 8'h90, 8'h00, 8'h03, 8'h11);  // LDI r3,0x11
        put2(16'h0004, 8'h33, 8'h2B);                // undefined, would target r3
        put4(16'h0006, 8'h90, 8'h00, 8'h06, 8'h66);  // LDI r6,0x66
        put2(16'h000A, 8'h7F, 8'h00);
        do_reset();
        run_to_halt(100, cyc);
        check("t6a_illegal", illegal, 1'b1);
        check("t6a_r3", dut.regs[3], 8'h11);
        check("t6a_r6", dut.regs[6], 8'h66);
        check("t6a_flags", flags, 4'b0000);

        // test 6b: reset asserted while fetching byte 2 of an ext instruction
        put2(16'h0000, 8'h33, 8'h00);
        put4(16'h0002, 8'h90, 8'h00, 8'h01, 8'hAA);
        put2(16'h0006, 8'h7F, 8'h00);
        do_reset();
        repeat (5) @(negedge clk);
        check("t6b_state_f2", dbg_state, F2);
        check("t6b_illegal_set", illegal, 1'b1);
        check("t6b_f2_mem_rd", mem_rd, 1'b1);
        check("t6b_f2_addr", mem_addr, 16'h0004);
        check("t6b_f2_pc", pc, 16'h0002);
        reset = 1'b1;
        #1;
        check("t6b_rst_mem_rd", mem_rd, 1'b0);
        @(negedge clk);
        check("t6b_rst_pc", pc, 16'h0000);
        check("t6b_rst_illegal", illegal, 1'b0);
        check("t6b_rst_state", dbg_state, F0);
        reset = 1'b0;
        #1;
        check("t6b_refetch_rd", mem_rd, 1'b1);
        check("t6b_refetch_addr", mem_addr, 16'h0000);
        run_to_halt(100, cyc);
        check("t6b_r1", dut.regs[1], 8'hAA);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
